// File: rtl/mem_access_bridge.sv
// mem_access_bridge: memory-stage bridge between the EX/MEM register and a
// multi-cycle valid/ready data bus. One load/store becomes one bus
// transaction. The pipeline stalls until the response (or a watchdog
// timeout) and then receives size-extracted, sign/zero-extended load data.
// Optional build macro: MEM_ALIGN_CHECK_EN. When it is defined, misaligned
// half/word accesses are rejected with a misalign_fault pulse. When it is
// not defined, such accesses are silently aligned down.
module mem_access_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic [2:0]  funct3,
  output logic [31:0] Read_data,
  output logic        mem_stall,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  output logic        bus_error,
  output logic        misalign_fault
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        fault_q;
  logic        misalign_hit;

  // Replicate store data across the lanes the byte enables select.
  function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Byte enables; a read never asserts any strobe.
  function automatic logic [3:0] lane_wstrb(input logic [1:0] off, input logic [2:0] f3,
                                            input logic we);
    if (!we) return 4'b0000;
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Pick the addressed byte/half out of the bus word and extend it.
  // funct3[2] selects zero-extension (lbu/lhu).
  function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  assign misalign_hit = is_misaligned(Address[1:0], funct3);
`else
  assign misalign_hit = 1'b0;
`endif

  // The hold comes from the live request in IDLE, so the detect cycle
  // already freezes the earlier pipeline stages.
  assign mem_stall = ((state_q == IDLE) && (MemRead || MemWrite)) ||
                     (state_q == REQ) || (state_q == WAIT);

  assign Read_data      = rdata_q;
  assign bus_req_valid  = valid_q;
  assign bus_we         = we_q;
  assign bus_addr       = addr_q;
  assign bus_wdata      = wdata_q;
  assign bus_wstrb      = wstrb_q;
  assign bus_error      = err_q;
  assign misalign_fault = fault_q;

  // Access FSM: latch the request, handshake it, wait with a watchdog, then release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MemRead || MemWrite) begin
            if (misalign_hit) begin
              // Rejected access: no bus traffic, loads return zero.
              state_q <= RESP;
              fault_q <= 1'b1;
              if (!MemWrite) rdata_q <= '0;
            end else begin
              state_q <= REQ;
              valid_q <= 1'b1;
              we_q    <= MemWrite;
              addr_q  <= {Address[31:2], 2'b00};
              off_q   <= Address[1:0];
              f3_q    <= funct3;
              wdata_q <= lane_wdata(Write_data, funct3);
              wstrb_q <= lane_wstrb(Address[1:0], funct3, MemWrite);
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the timeout cycle still wins.
          if (bus_rsp_valid) begin
            state_q <= RESP;
            if (!we_q) rdata_q <= extract_load(bus_rdata, off_q, f3_q);
          end else if (cnt_q + 16'd1 == TIMEOUT_W) begin
            state_q <= RESP;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_bridge.sv
// Directed bench for mem_access_bridge with TIMEOUT_CYCLES=4.
// Honours MEM_ALIGN_CHECK_EN to pick the misaligned-access expectation.
module tb_mem_access_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] Address, Write_data;
  logic [2:0]  funct3;
  logic [31:0] Read_data;
  logic        mem_stall;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        bus_error, misalign_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_data(Write_data), .funct3(funct3),
    .Read_data(Read_data), .mem_stall(mem_stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata(bus_rdata), .bus_error(bus_error),
    .misalign_fault(misalign_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full 4-cycle access: detect, REQ with ready, WAIT with rsp, RESP.
  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] f3,
                            input logic [31:0] rsp_word, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                            input logic [31:0] exp_rd);
    MemWrite = we; MemRead = ~we; Address = addr; Write_data = wd; funct3 = f3;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
    #1 check_eq({tag, ".idle_stall"}, 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; Address = 32'hFFFF_FFFF; Write_data = 32'h0; funct3 = 3'b000;
    check_eq({tag, ".req_valid"}, 32'(bus_req_valid), 32'd1);
    check_eq({tag, ".req_we"}, 32'(bus_we), 32'(we));
    check_eq({tag, ".req_addr"}, bus_addr, exp_addr);
    check_eq({tag, ".req_wdata"}, bus_wdata, exp_wdata);
    check_eq({tag, ".req_wstrb"}, 32'(bus_wstrb), 32'(exp_strb));
    check_eq({tag, ".req_stall"}, 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    check_eq({tag, ".wait_valid"}, 32'(bus_req_valid), 32'd0);
    check_eq({tag, ".wait_stall"}, 32'(mem_stall), 32'd1);
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = rsp_word;
    @(posedge clk); #1;
    check_eq({tag, ".resp_stall"}, 32'(mem_stall), 32'd0);
    check_eq({tag, ".resp_rdata"}, Read_data, exp_rd);
    check_eq({tag, ".resp_err"}, 32'(bus_error), 32'd0);
    check_eq({tag, ".resp_fault"}, 32'(misalign_fault), 32'd0);
    bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    @(posedge clk); #1;
    check_eq({tag, ".idle_rdata_hold"}, Read_data, exp_rd);
  endtask

  // Issue a word load and bring it into WAIT with the slave silent.
  task automatic start_lw(input logic [31:0] addr);
    MemRead = 1'b1; MemWrite = 1'b0; Address = addr; funct3 = 3'b010;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
    @(posedge clk); #1;
    MemRead = 1'b0;
    check_eq("start.req_valid", 32'(bus_req_valid), 32'd1);
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Address = 32'h0; Write_data = 32'h0;
    funct3 = 3'b000; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    #12;
    check_eq("rst.rdata", Read_data, 32'h0);
    check_eq("rst.valid", 32'(bus_req_valid), 32'd0);
    check_eq("rst.we", 32'(bus_we), 32'd0);
    check_eq("rst.addr", bus_addr, 32'h0);
    check_eq("rst.wdata", bus_wdata, 32'h0);
    check_eq("rst.wstrb", 32'(bus_wstrb), 32'd0);
    check_eq("rst.err", 32'(bus_error), 32'd0);
    check_eq("rst.fault", 32'(misalign_fault), 32'd0);
    check_eq("rst.stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    //          tag     we    addr          wdata         f3      rsp word      bus_addr      bus_wdata     strb     Read_data
    run_access("lw",   1'b0, 32'h0000_0010, 32'h0,        3'b010, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0,        4'b0000, 32'hDEAD_BEEF);
    run_access("sb",   1'b1, 32'h0000_0013, 32'h0000_00A5, 3'b000, 32'h1234_5678, 32'h0000_0010, 32'hA5A5_A5A5, 4'b1000, 32'hDEAD_BEEF);
    run_access("lb",   1'b0, 32'h0000_0022, 32'h0,        3'b000, 32'h0080_0000, 32'h0000_0020, 32'h0,        4'b0000, 32'hFFFF_FF80);
    run_access("lbu",  1'b0, 32'h0000_0022, 32'h0,        3'b100, 32'h0080_0000, 32'h0000_0020, 32'h0,        4'b0000, 32'h0000_0080);
    run_access("lh",   1'b0, 32'h0000_0022, 32'h0,        3'b001, 32'h8001_0000, 32'h0000_0020, 32'h0,        4'b0000, 32'hFFFF_8001);
    run_access("lhu",  1'b0, 32'h0000_0020, 32'h0,        3'b101, 32'h1234_F00D, 32'h0000_0020, 32'h0,        4'b0000, 32'h0000_F00D);
    run_access("sh",   1'b1, 32'h0000_0006, 32'hBEEF_1234, 3'b001, 32'h0,        32'h0000_0004, 32'h1234_1234, 4'b1100, 32'h0000_F00D);
    run_access("sw",   1'b1, 32'h0000_0008, 32'hCAFE_BABE, 3'b010, 32'h0,        32'h0000_0008, 32'hCAFE_BABE, 4'b1111, 32'h0000_F00D);
    run_access("lw111",1'b0, 32'h0000_0030, 32'h0,        3'b111, 32'h8000_0001, 32'h0000_0030, 32'h0,        4'b0000, 32'h8000_0001);

    // Watchdog: silent slave, four WAIT cycles then RESP with error.
    start_lw(32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      check_eq("tmo.wait_stall", 32'(mem_stall), 32'd1);
      check_eq("tmo.wait_err", 32'(bus_error), 32'd0);
      @(posedge clk); #1;
    end
    check_eq("tmo.resp_err", 32'(bus_error), 32'd1);
    check_eq("tmo.resp_rdata", Read_data, 32'h0);
    check_eq("tmo.resp_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    check_eq("tmo.idle_err", 32'(bus_error), 32'd0);
    check_eq("tmo.idle_stall", 32'(mem_stall), 32'd0);

    // Response on the very cycle the watchdog would expire wins.
    start_lw(32'h0000_0050);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check_eq("race.wait4_stall", 32'(mem_stall), 32'd1);
    bus_rsp_valid = 1'b1; bus_rdata = 32'h1122_3344;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    check_eq("race.err", 32'(bus_error), 32'd0);
    check_eq("race.rdata", Read_data, 32'h1122_3344);
    check_eq("race.stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in WAIT.
    start_lw(32'h0000_0070);
    check_eq("arst.pre_stall", 32'(mem_stall), 32'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("arst.valid", 32'(bus_req_valid), 32'd0);
    check_eq("arst.stall", 32'(mem_stall), 32'd0);
    check_eq("arst.rdata", Read_data, 32'h0);
    check_eq("arst.addr", bus_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    run_access("lw_after_rst", 1'b0, 32'h0000_0074, 32'h0, 3'b010, 32'h0BAD_F00D,
               32'h0000_0074, 32'h0, 4'b0000, 32'h0BAD_F00D);

    // Misaligned word load.
`ifdef MEM_ALIGN_CHECK_EN
    MemRead = 1'b1; MemWrite = 1'b0; Address = 32'h0000_0061; funct3 = 3'b010;
    bus_req_ready = 1'b1;
    #1 check_eq("mis.idle_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    MemRead = 1'b0;
    check_eq("mis.fault", 32'(misalign_fault), 32'd1);
    check_eq("mis.valid", 32'(bus_req_valid), 32'd0);
    check_eq("mis.stall", 32'(mem_stall), 32'd0);
    check_eq("mis.rdata", Read_data, 32'h0);
    @(posedge clk); #1;
    check_eq("mis.fault_clear", 32'(misalign_fault), 32'd0);
    check_eq("mis.valid_idle", 32'(bus_req_valid), 32'd0);
`else
    run_access("lw_mis", 1'b0, 32'h0000_0061, 32'h0, 3'b010, 32'h5555_AAAA,
               32'h0000_0060, 32'h0, 4'b0000, 32'h5555_AAAA);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
